serv_rf_dbg_arb: RTL

//  Shares one serv_rf_ram instance between the SERV core RF interface and a word-wide

---
 rtl/serv_rf_dbg_pkg.sv | 28 ++
 rtl/serv_rf_dbg_arb.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serv_rf_dbg_pkg.sv
// Shared definitions for the SERV register-file debug arbiter: FSM encoding and
// the derived beat/address geometry helpers.
package serv_rf_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } dbg_state_e;

  function automatic int beats_f(input int width);
    return 32 / width;
  endfunction

  function automatic int bw_f(input int width);
    return $clog2(32 / width);
  endfunction

  function automatic int aw_f(input int width, input int csr_regs);
    return $clog2((32 + csr_regs) * (32 / width));
  endfunction

  function automatic int rw_f(input int width, input int csr_regs);
    return aw_f(width, csr_regs) - bw_f(width);
  endfunction

endpackage

// File: rtl/serv_rf_dbg_arb.sv
// Shares one serv_rf_ram between the SERV core RF port and a 32-bit debug port.
// The core always wins; debug beats slip into cycles where the core leaves a port idle.
module serv_rf_dbg_arb
  import serv_rf_dbg_pkg::*;
#(
  parameter int  WIDTH    = 2,
  parameter int  CSR_REGS = 4,
  localparam int BEATS    = beats_f(WIDTH),
  localparam int BW       = bw_f(WIDTH),
  localparam int AW       = aw_f(WIDTH, CSR_REGS),
  localparam int RW       = rw_f(WIDTH, CSR_REGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [AW-1:0]    i_core_waddr,
  input  logic [WIDTH-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic [AW-1:0]    i_core_raddr,
  input  logic             i_core_ren,
  output logic [WIDTH-1:0] o_core_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [RW-1:0]    i_dbg_reg,
  input  logic [31:0]      i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic [31:0]      o_dbg_rdata,
  output logic             o_dbg_busy,
  output logic [AW-1:0]    o_ram_waddr,
  output logic [WIDTH-1:0] o_ram_wdata,
  output logic             o_ram_wen,
  output logic [AW-1:0]    o_ram_raddr,
  output logic             o_ram_ren,
  input  logic [WIDTH-1:0] i_ram_rdata
);

  localparam int            BW1       = BW + 1;
  localparam logic [BW:0]   BEAT_LAST = BW1'(BEATS - 1);
  localparam logic [BW-1:0] TAG_LAST  = BW'(BEATS - 1);

  dbg_state_e       r_state;
  logic [BW:0]      r_beat;
  logic [BW-1:0]    r_tag;
  logic             r_cap;
  logic [RW-1:0]    r_reg;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rbuf;
  logic [31:0]      r_rdata;
  logic             r_ack;

  logic             w_dbg_wen;
  logic             w_dbg_ren;
  logic [AW-1:0]    w_dbg_addr;
  logic [WIDTH-1:0] w_dbg_wbeat;
  logic [31:0]      w_rbuf_next;

  // r_beat carries one extra bit so the read issuer can tell when all beats are out.
  assign w_dbg_wen   = (r_state == ST_WR) && !i_core_wen;
  assign w_dbg_ren   = (r_state == ST_RD) && !i_core_ren && !r_beat[BW];
  assign w_dbg_addr  = {r_reg, r_beat[BW-1:0]};
  assign w_dbg_wbeat = r_wdata[r_beat[BW-1:0]*WIDTH +: WIDTH];

  assign o_core_rdata = i_ram_rdata;
  assign o_dbg_ack    = r_ack;
  assign o_dbg_rdata  = r_rdata;
  assign o_dbg_busy   = (r_state != ST_IDLE);

  // Write-port mux: a debug beat only exists when the core write port is idle.
  always_comb begin
    o_ram_wen   = i_core_wen;
    o_ram_waddr = i_core_waddr;
    o_ram_wdata = i_core_wdata;
    if (w_dbg_wen) begin
      o_ram_wen   = 1'b1;
      o_ram_waddr = w_dbg_addr;
      o_ram_wdata = w_dbg_wbeat;
    end else begin
      o_ram_wen   = i_core_wen;
    end
  end

  // Read-port mux, independent of the write port.
  always_comb begin
    o_ram_ren   = i_core_ren;
    o_ram_raddr = i_core_raddr;
    if (w_dbg_ren) begin
      o_ram_ren   = 1'b1;
      o_ram_raddr = w_dbg_addr;
    end else begin
      o_ram_ren   = i_core_ren;
    end
  end

  // Read data lands one cycle after issue, even if the core owns the read port by then.
  always_comb begin
    w_rbuf_next = r_rbuf;
    if (r_cap) begin
      w_rbuf_next[r_tag*WIDTH +: WIDTH] = i_ram_rdata;
    end else begin
      w_rbuf_next = r_rbuf;
    end
  end

  // Transaction FSM, beat counter and capture pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_tag   <= '0;
      r_cap   <= 1'b0;
      r_reg   <= '0;
      r_wdata <= 32'h0;
      r_rbuf  <= 32'h0;
      r_rdata <= 32'h0;
      r_ack   <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_cap  <= 1'b0;
      r_rbuf <= w_rbuf_next;
      case (r_state)
        ST_IDLE: begin
          if (i_dbg_req) begin
            r_reg   <= i_dbg_reg;
            r_wdata <= i_dbg_wdata;
            r_beat  <= '0;
            if (i_dbg_we && (i_dbg_reg == '0)) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end else if (i_dbg_we) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_WR: begin
          if (w_dbg_wen) begin
            r_beat <= r_beat + BW1'(1);
            if (r_beat == BEAT_LAST) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (w_dbg_ren) begin
            r_cap  <= 1'b1;
            r_tag  <= r_beat[BW-1:0];
            r_beat <= r_beat + BW1'(1);
          end
          if (r_cap && (r_tag == TAG_LAST)) begin
            r_rdata <= w_rbuf_next;
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
